search_ctrl: RTL and testbench

- Sequencing controller for the RAM search datapath (spreg RAM, compare, register_adr, address mux).
- On a start pulse, scans RAM addresses 0..R-1 with one read issued per clock and compares each word against a latched key.
- Reports the first matching address with a done/found handshake.
- Drives the RAM read address, RAM enable and read-side mux select; replaces hand-driven select/reset strobes.

---
 rtl/search_pkg.sv | 12 +
 rtl/search_ctrl_scan_counter.sv | 26 ++
 rtl/search_ctrl.sv | 132 +++++++++++++
 tb/tb_search_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/search_pkg.sv
// search_pkg: controller states and default sizes shared by the RAM search blocks
package search_pkg;
   localparam int A_DEF = 8;
   localparam int D_DEF = 8;
   localparam int R_DEF = 256;
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SCAN  = 2'b01,
      S_DRAIN = 2'b10,
      S_FIN   = 2'b11
   } state_t;
endpackage

// File: rtl/search_ctrl_scan_counter.sv
// scan_counter: A-bit address counter that stops at R-1 instead of wrapping
//   clk/reset : clock, synchronous active-low reset
//   clr, en   : clear to 0 (wins over en), advance by one
//   cnt, term : current address, high while cnt == R-1
module scan_counter
   import search_pkg::*;
#(
   parameter int A = A_DEF,
   parameter int R = R_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [A-1:0] cnt,
   output logic         term
);
   logic [A-1:0] cnt_q, cnt_d;
   assign cnt  = cnt_q;
   assign term = cnt_q == A'(R - 1);
   always_comb cnt_d = clr ? '0 : (en && !term) ? cnt_q + A'(1) : cnt_q;
   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/search_ctrl.sv
// search_ctrl: scans RAM words 0..R-1 for a latched key and reports the first matching address
//   inputs : clk, reset (sync, active-low), start, key, ram_rd_data (valid one clock after address)
//   outputs: ram_addr/ram_ce/ram_we/rd_sel to the RAM and mux, busy, done pulse, found, match_adr
//   SEARCH_MATCH_COUNT_EN: scan every word and add match_cnt (total matches) instead of stopping early
module search_ctrl
   import search_pkg::*;
#(
   parameter int A = A_DEF,
   parameter int D = D_DEF,
   parameter int R = R_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [D-1:0] key,
   input  logic [D-1:0] ram_rd_data,
   output logic [A-1:0] ram_addr,
   output logic         ram_ce,
   output logic         ram_we,
   output logic         rd_sel,
   output logic         busy,
   output logic         done,
   output logic         found,
`ifdef SEARCH_MATCH_COUNT_EN
   output logic [A:0]   match_cnt,
`endif
   output logic [A-1:0] match_adr
);
   state_t       state_q, state_d;
   logic [D-1:0] key_q, key_d;
   logic         found_q, found_d;
   logic [A-1:0] match_adr_q, match_adr_d;
   // address whose read data is on ram_rd_data this cycle, and its valid bit
   logic [A-1:0] rd_adr_q, rd_adr_d;
   logic         rd_v_q, rd_v_d;
   logic         cnt_clr, cnt_en, cnt_term, hit;
   logic [A-1:0] cnt;
`ifdef SEARCH_MATCH_COUNT_EN
   logic [A:0]   match_cnt_q, match_cnt_d;
   assign match_cnt = match_cnt_q;
`endif
   scan_counter #(.A(A), .R(R)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .cnt  (cnt),
      .term (cnt_term)
   );
   assign hit       = rd_v_q && (ram_rd_data == key_q);
   assign ram_addr  = cnt;
   assign ram_ce    = state_q == S_SCAN;
   assign ram_we    = 1'b0;
   assign busy      = state_q != S_IDLE;
   assign rd_sel    = busy;
   assign done      = state_q == S_FIN;
   assign found     = found_q;
   assign match_adr = match_adr_q;
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      found_d     = found_q;
      match_adr_d = match_adr_q;
      rd_adr_d    = rd_adr_q;
      rd_v_d      = 1'b0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
`ifdef SEARCH_MATCH_COUNT_EN
      match_cnt_d = match_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_SCAN;
               key_d       = key;
               found_d     = 1'b0;
               match_adr_d = '0;
               cnt_clr     = 1'b1;
`ifdef SEARCH_MATCH_COUNT_EN
               match_cnt_d = '0;
`endif
            end
         end
         S_SCAN, S_DRAIN: begin
            // only the first hit records its address, so the lowest duplicate wins
            if (hit && !found_q) begin
               found_d     = 1'b1;
               match_adr_d = rd_adr_q;
            end
`ifdef SEARCH_MATCH_COUNT_EN
            if (hit) match_cnt_d = match_cnt_q + {{A{1'b0}}, 1'b1};
`endif
            if (state_q == S_SCAN) begin
               cnt_en   = 1'b1;
               rd_v_d   = 1'b1;
               rd_adr_d = cnt;
`ifdef SEARCH_MATCH_COUNT_EN
               state_d  = cnt_term ? S_DRAIN : S_SCAN;
`else
               state_d  = hit ? S_FIN : cnt_term ? S_DRAIN : S_SCAN;
`endif
            end else begin
               state_d = S_FIN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         key_q       <= '0;
         found_q     <= 1'b0;
         match_adr_q <= '0;
         rd_adr_q    <= '0;
         rd_v_q      <= 1'b0;
`ifdef SEARCH_MATCH_COUNT_EN
         match_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         found_q     <= found_d;
         match_adr_q <= match_adr_d;
         rd_adr_q    <= rd_adr_d;
         rd_v_q      <= rd_v_d;
`ifdef SEARCH_MATCH_COUNT_EN
         match_cnt_q <= match_cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_search_ctrl.sv
// tb_search_ctrl: directed bench for search_ctrl with a behavioural one-cycle-latency RAM
module tb_search_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] key = 8'h00;
   logic [7:0] ram_rd_data = 8'h00;
   logic [7:0] ram_addr;
   logic       ram_ce, ram_we, rd_sel, busy, done, found;
   logic [7:0] match_adr;
   logic [7:0] mem [256];
   int         checks = 0;
   int         failures = 0;
   int         dc;
   int         pulses;
`ifdef SEARCH_MATCH_COUNT_EN
   logic [8:0] match_cnt;
`endif
   search_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .key        (key),
      .ram_rd_data(ram_rd_data),
      .ram_addr   (ram_addr),
      .ram_ce     (ram_ce),
      .ram_we     (ram_we),
      .rd_sel     (rd_sel),
      .busy       (busy),
      .done       (done),
      .found      (found),
`ifdef SEARCH_MATCH_COUNT_EN
      .match_cnt  (match_cnt),
`endif
      .match_adr  (match_adr)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (ram_ce) ram_rd_data <= mem[ram_addr];
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic fill(input int mode, input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = (mode == 0) ? 8'(i) : v;
   endtask
   // start a search from IDLE and check the completion handshake in cycle d
   task automatic run(input string tag, input logic [7:0] k, input int d, input logic f,
                      input logic [7:0] ma, input logic ce_pre);
      key = k;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk({tag, "_busy_c1"}, busy, 1);
      chk({tag, "_found_clr"}, found, 0);
      chk({tag, "_adr_clr"}, match_adr, 0);
      tick(d - 2);
      chk({tag, "_done_early"}, done, 0);
      chk({tag, "_ce_pre"}, ram_ce, ce_pre);
      tick(1);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_found"}, found, f);
      chk({tag, "_match_adr"}, match_adr, ma);
      chk({tag, "_ce_fin"}, ram_ce, 0);
      tick(1);
      chk({tag, "_busy_low"}, busy, 0);
      chk({tag, "_done_low"}, done, 0);
   endtask
   function automatic int done_at(input int k);
`ifdef SEARCH_MATCH_COUNT_EN
      return 258;
`else
      return k + 3;
`endif
   endfunction
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      fill(0, 8'h00);
      tick(2);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_found", found, 0);
      chk("rst_adr", match_adr, 0);
      chk("rst_ce", ram_ce, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_rdsel", rd_sel, 0);
      chk("rst_addr", ram_addr, 0);
      reset = 1'b1;
      tick(1);
      // key 0x05 over mem[i]=i: addresses 0..6 issued in cycles 1..7
      key = 8'h05;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         chk($sformatf("a_addr_c%0d", c), ram_addr, c - 1);
         chk($sformatf("a_ce_c%0d", c), ram_ce, 1);
         chk($sformatf("a_rdsel_c%0d", c), rd_sel, 1);
         if (c < 7) tick(1);
      end
      dc = done_at(5);
      tick(dc - 7);
      chk("a_done", done, 1);
      chk("a_found", found, 1);
      chk("a_adr", match_adr, 8'h05);
      tick(1);
      chk("a_busy_low", busy, 0);
      chk("a_found_hold", found, 1);
      chk("a_adr_hold", match_adr, 8'h05);
      run("b", 8'h00, done_at(0), 1'b1, 8'h00, 1'b1);
      fill(1, 8'hAA);
      run("c", 8'h55, 258, 1'b0, 8'h00, 1'b0);
      fill(1, 8'h00);
      mem[255] = 8'hAA;
      run("d", 8'hAA, 258, 1'b1, 8'hFF, 1'b0);
      // duplicates at 3 and 9; a re-pulsed start with another key must be ignored
      fill(1, 8'h00);
      mem[3] = 8'h3C;
      mem[9] = 8'h3C;
      key = 8'h3C;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(3);
      key = 8'h11;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      dc = done_at(3);
      tick(dc - 5);
      chk("e_done", done, 1);
      chk("e_found", found, 1);
      chk("e_adr", match_adr, 8'h03);
`ifdef SEARCH_MATCH_COUNT_EN
      chk("e_cnt", match_cnt, 2);
`endif
      tick(1);
      chk("e_busy_low", busy, 0);
      // reset sampled low at the end of cycle 50 of a no-match search
      fill(1, 8'hAA);
      key = 8'h55;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(49);
      chk("f_busy_c50", busy, 1);
      reset = 1'b0;
      tick(1);
      chk("f_busy", busy, 0);
      chk("f_done", done, 0);
      chk("f_found", found, 0);
      chk("f_ce", ram_ce, 0);
      chk("f_addr", ram_addr, 0);
      reset = 1'b1;
      pulses = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         if (done) pulses++;
      end
      chk("f_no_done", pulses, 0);
      fill(0, 8'h00);
      run("f2", 8'h05, done_at(5), 1'b1, 8'h05, 1'b1);
      // start held high: back-to-back searches
      key = 8'h02;
      dc = done_at(2);
      start = 1'b1;
      tick(dc);
      chk("g_done1", done, 1);
      chk("g_found1", found, 1);
      chk("g_adr1", match_adr, 8'h02);
      tick(1);
      chk("g_idle", busy, 0);
      chk("g_found_idle", found, 1);
      tick(1);
      chk("g_busy2", busy, 1);
      chk("g_found_clr", found, 0);
      chk("g_adr_clr", match_adr, 0);
      tick(dc - 1);
      chk("g_done2", done, 1);
      chk("g_found2", found, 1);
      chk("g_adr2", match_adr, 8'h02);
      start = 1'b0;
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
